// File: rtl/mac_arb_pkg.sv
// Shared types and constants for the FP MAC round-robin arbiter.
package mac_arb_pkg;

  localparam int unsigned FP_W    = 32;
  localparam logic [2:0]  RND_RNE = 3'b000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mac_rsp_pipe.sv
// Fixed-latency response delay line: carries the one-hot owner tag and the
// MAC result from issue to the response port, shifting every cycle.
module mac_rsp_pipe #(
  parameter int unsigned PIPE_LAT = 2,
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned FP_W     = mac_arb_pkg::FP_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] in_tag,
  input  logic [FP_W-1:0]    in_data,
  output logic [NUM_REQ-1:0] out_tag,
  output logic [FP_W-1:0]    out_data,
  output logic               busy
);

  logic [NUM_REQ-1:0] tag_q  [PIPE_LAT];
  logic [FP_W-1:0]    data_q [PIPE_LAT];

  // Stage 1 captures the issue, later stages shift unconditionally; data is
  // zeroed on empty slots so the output needs no extra gating.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < PIPE_LAT; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      tag_q[0]  <= in_tag;
      data_q[0] <= (|in_tag) ? in_data : '0;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        tag_q[i]  <= tag_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  // Busy whenever any stage holds a result.
  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i < PIPE_LAT; i++) begin
      busy = busy | (|tag_q[i]);
    end
  end

  assign out_tag  = tag_q[PIPE_LAT-1];
  assign out_data = data_q[PIPE_LAT-1];

endmodule

// File: rtl/mac_rr_arbiter.sv
// Round-robin arbiter sharing one external FP MAC between NUM_REQ requesters,
// with a fixed-latency tagged response path and a drain handshake.
module mac_rr_arbiter
  import mac_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  input  logic [NUM_REQ*FP_W-1:0] req_c,
  output logic [FP_W-1:0]         mac_a,
  output logic [FP_W-1:0]         mac_b,
  output logic [FP_W-1:0]         mac_c,
  output logic [2:0]              mac_rnd,
  input  logic [FP_W-1:0]         mac_z,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [FP_W-1:0]         rsp_data,
  input  logic                    drain,
  output logic                    drain_done,
  output logic                    busy
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr, gnt_idx, cand, ptr_next;
  logic [NUM_REQ-1:0] gnt_oh;
  logic               gnt_found, grant_en, transfer, pipe_busy;

  assign grant_en = (state_q == RUN) && !drain && !reset;

  // First valid requester searching upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_oh    = '0;
    cand      = '0;
    if (grant_en) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = PTR_W'((32'(rr_ptr) + k) % NUM_REQ);
        if (!gnt_found && req_valid[cand]) begin
          gnt_found    = 1'b1;
          gnt_idx      = cand;
          gnt_oh[cand] = 1'b1;
        end
      end
    end
  end

  assign req_ready = gnt_oh;
  assign transfer  = |(req_valid & gnt_oh);
  assign ptr_next  = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

  // Operand mux towards the MAC; zero when nobody is granted.
  always_comb begin
    mac_a = '0;
    mac_b = '0;
    mac_c = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt_oh[k]) begin
        mac_a = req_a[k*FP_W +: FP_W];
        mac_b = req_b[k*FP_W +: FP_W];
        mac_c = req_c[k*FP_W +: FP_W];
      end
    end
  end

  assign mac_rnd = RND_RNE;

  // Round-robin pointer advances past the winner only on a real transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (transfer) begin
      rr_ptr <= ptr_next;
    end
  end

  // Drain sequencing; DRAIN runs to completion regardless of drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (drain)      state_d = DRAIN;
      DRAIN:   if (!pipe_busy) state_d = DONE;
      DONE:    if (!drain)     state_d = RUN;
      default:                 state_d = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  mac_rsp_pipe #(
    .PIPE_LAT (PIPE_LAT),
    .NUM_REQ  (NUM_REQ),
    .FP_W     (FP_W)
  ) u_rsp_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_tag   (req_valid & gnt_oh),
    .in_data  (mac_z),
    .out_tag  (rsp_valid),
    .out_data (rsp_data),
    .busy     (pipe_busy)
  );

  assign busy       = pipe_busy;
  assign drain_done = (state_q == DONE);

endmodule

// File: tb/tb_mac_rr_arbiter.sv
// Scoreboard bench for mac_rr_arbiter (NUM_REQ=2, PIPE_LAT=2).
module tb_mac_rr_arbiter;

  localparam int N  = 2;
  localparam int PL = 2;

  logic        clk, reset, drain;
  logic [1:0]  req_valid, req_ready, rsp_valid;
  logic [63:0] req_a, req_b, req_c;
  logic [31:0] mac_a, mac_b, mac_c, mac_z, rsp_data;
  logic [2:0]  mac_rnd;
  logic        drain_done, busy;

  typedef struct {
    logic [1:0]  tag;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  int   m_ptr  = 0;

  mac_rr_arbiter #(.NUM_REQ(N), .PIPE_LAT(PL)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_c      (req_c),
    .mac_a      (mac_a),
    .mac_b      (mac_b),
    .mac_c      (mac_c),
    .mac_rnd    (mac_rnd),
    .mac_z      (mac_z),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .drain      (drain),
    .drain_done (drain_done),
    .busy       (busy)
  );

  // Stand-in for the external MAC: exact for the reference triple, integer hash otherwise.
  function automatic logic [31:0] fmac(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    if (a == 32'h3F800000 && b == 32'h40000000 && c == 32'h3F000000) return 32'h40200000;
    return a * b + c;
  endfunction

  assign mac_z = fmac(mac_a, mac_b, mac_c);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $fatal(1, "watchdog");
  end

  // Response scoreboard: every cycle either the due entry or an idle port.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (rsp_valid !== e.tag || rsp_data !== e.data) begin
        errors++;
        $display("FAIL rsp cyc=%0d: got valid=%b data=%h, expected valid=%b data=%h",
                 cyc, rsp_valid, rsp_data, e.tag, e.data);
      end
    end else begin
      checks++;
      if (rsp_valid !== 2'b00 || rsp_data !== 32'h0) begin
        errors++;
        $display("FAIL rsp_idle cyc=%0d: got valid=%b data=%h, expected 00/0",
                 cyc, rsp_valid, rsp_data);
      end
    end
  end

  function automatic logic [1:0] model_grant(input logic [1:0] v);
    logic [1:0] g;
    g = '0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (g == 2'b00 && v[idx]) g[idx] = 1'b1;
    end
    return g;
  endfunction

  task automatic drive(input logic [1:0] v, input logic d);
    @(posedge clk);
    #1;
    req_valid = v;
    drain     = d;
    for (int i = 0; i < N; i++) begin
      req_a[i*32 +: 32] = $urandom;
      req_b[i*32 +: 32] = $urandom;
      req_c[i*32 +: 32] = $urandom;
    end
  endtask

  task automatic accept(input logic [1:0] g);
    int idx;
    if (g == 2'b00) return;
    idx = g[1] ? 1 : 0;
    sb.push_back('{g, fmac(req_a[idx*32 +: 32], req_b[idx*32 +: 32], req_c[idx*32 +: 32]), cyc + PL});
    m_ptr = (idx + 1) % N;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(2'b00, 1'b0);
  endtask

  task automatic do_reset();
    drive(2'b00, 1'b0);
    reset = 1'b1;
    while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
    drive(2'b00, 1'b0);
    reset = 1'b0;
    m_ptr = 0;
  endtask

  task automatic test_reset();
    drive(2'b11, 1'b0);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
    checks++;
    if (busy !== 1'b0 || drain_done !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got busy=%b drain_done=%b expected 0/0", busy, drain_done);
    end
    checks++;
    if (mac_a !== 32'h0 || mac_rnd !== 3'b000) begin
      errors++; $display("FAIL reset_mac: got mac_a=%h rnd=%b expected 0/000", mac_a, mac_rnd);
    end
    drive(2'b00, 1'b0);
    reset = 1'b0;
    m_ptr = 0;
    idle(1);
  endtask

  task automatic test_single();
    drive(2'b01, 1'b0);
    req_a[31:0] = 32'h3F800000;
    req_b[31:0] = 32'h40000000;
    req_c[31:0] = 32'h3F000000;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b expected 01", req_ready); end
    checks++;
    if (mac_a !== 32'h3F800000 || mac_b !== 32'h40000000 || mac_c !== 32'h3F000000) begin
      errors++; $display("FAIL single_ops: got %h %h %h expected 3f800000 40000000 3f000000", mac_a, mac_b, mac_c);
    end
    sb.push_back('{2'b01, 32'h40200000, cyc + PL});
    m_ptr = 1;
    drive(2'b00, 1'b0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    idle(3);
  endtask

  task automatic test_contention();
    logic [1:0] exp_g [4];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 1'b0);
      @(negedge clk);
      checks++;
      if (req_ready !== exp_g[i]) begin
        errors++; $display("FAIL contention_grant[%0d]: got %b expected %b", i, req_ready, exp_g[i]);
      end
      accept(exp_g[i]);
    end
    idle(3);
  endtask

  task automatic test_fairness();
    logic       r0;
    logic [1:0] g, prev;
    r0   = 1'b1;
    prev = 2'b00;
    for (int i = 0; i < 8; i++) begin
      drive({1'b1, r0}, 1'b0);
      g = model_grant({1'b1, r0});
      @(negedge clk);
      checks++;
      if (req_ready !== g) begin errors++; $display("FAIL fair_grant[%0d]: got %b expected %b", i, req_ready, g); end
      checks++;
      if (req_ready === 2'b01 && prev === 2'b01) begin
        errors++; $display("FAIL fair_repeat[%0d]: got two req0 grants, expected alternation", i);
      end
      prev = req_ready;
      accept(g);
      r0 = (g == 2'b01);
    end
    idle(3);
  endtask

  task automatic test_withdraw();
    logic [1:0] g;
    drive(2'b00, 1'b0);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL withdraw_idle: got %b expected 00", req_ready); end
    drive(2'b11, 1'b0);
    g = model_grant(2'b11);
    @(negedge clk);
    checks++;
    if (req_ready !== g) begin errors++; $display("FAIL withdraw_ptr: got %b expected %b", req_ready, g); end
    accept(g);
    idle(3);
  endtask

  task automatic test_drain();
    logic [1:0] g;
    logic       dr   [5];
    logic       bsy  [5];
    logic       dd   [5];
    dr  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    bsy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    dd  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      drive(2'b11, 1'b0);
      g = model_grant(2'b11);
      @(negedge clk);
      checks++;
      if (req_ready !== g) begin errors++; $display("FAIL drain_issue[%0d]: got %b expected %b", i, req_ready, g); end
      accept(g);
    end
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, dr[i]);
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b00 || busy !== bsy[i] || drain_done !== dd[i]) begin
        errors++;
        $display("FAIL drain_step[%0d]: got ready=%b busy=%b done=%b expected 00/%b/%b",
                 i, req_ready, busy, drain_done, bsy[i], dd[i]);
      end
    end
    drive(2'b11, 1'b0);
    g = model_grant(2'b11);
    @(negedge clk);
    checks++;
    if (req_ready !== g || g === 2'b00 || drain_done !== 1'b0) begin
      errors++; $display("FAIL drain_resume: got ready=%b done=%b expected %b/0", req_ready, drain_done, g);
    end
    accept(g);
    idle(3);
  endtask

  task automatic test_idle_drain();
    logic       dr [4];
    logic       dd [4];
    logic [1:0] g;
    dr = '{1'b1, 1'b1, 1'b1, 1'b0};
    dd = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(2'b00, dr[i]);
      @(negedge clk);
      checks++;
      if (drain_done !== dd[i]) begin
        errors++; $display("FAIL idle_drain[%0d]: got %b expected %b", i, drain_done, dd[i]);
      end
    end
    drive(2'b11, 1'b0);
    g = model_grant(2'b11);
    @(negedge clk);
    checks++;
    if (req_ready !== g || drain_done !== 1'b0) begin
      errors++; $display("FAIL idle_drain_resume: got ready=%b done=%b expected %b/0", req_ready, drain_done, g);
    end
    accept(g);
    idle(3);
  endtask

  task automatic test_reset_midflight();
    drive(2'b01, 1'b0);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL rmid_issue: got %b expected 01", req_ready); end
    accept(2'b01);
    drive(2'b11, 1'b0);
    reset = 1'b1;
    while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL rmid_ready: got %b expected 00", req_ready); end
    drive(2'b00, 1'b0);
    reset = 1'b0;
    m_ptr = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    idle(2);
    drive(2'b11, 1'b0);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL rmid_ptr: got %b expected 01", req_ready); end
    accept(2'b01);
    idle(3);
  endtask

  initial begin
    reset     = 1'b1;
    drain     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_withdraw();
    test_drain();
    test_idle_drain();
    test_reset_midflight();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_empty: got %0d pending responses expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_rr_arbiter.md
MAC_RR_ARBITER -- requirements
Module: mac_rr_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter NUM_REQ, default 2, SHALL set the number of requesters sharing one FP MAC (range 2..8).
REQ-003 Parameter PIPE_LAT, default 2, SHALL set the response latency in cycles after issue (range 1..4).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 req_valid  in  NUM_REQ  per-requester operand-triple valid.
REQ-007 req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
REQ-008 req_a, req_b, req_c  in  NUM_REQ*32 each  packed IEEE-754 single operands; requester i occupies bits [32i+31:32i].
REQ-009 mac_a, mac_b, mac_c  out  32 each  operands to the external DW_fp_mac instance.
REQ-010 mac_rnd  out  3  rounding mode, constant 3'b000 (round to nearest even).
REQ-011 mac_z  in  32  combinational MAC result for the current mac_a*mac_b+mac_c.
REQ-012 rsp_valid  out  NUM_REQ  one-hot response strobe; the bit identifies the owning requester.
REQ-013 rsp_data  out  32  MAC result for the strobed requester.
REQ-014 drain  in  1  request to stop issuing and empty the pipeline.
REQ-015 drain_done  out  1  high while stopped with an empty pipeline.
REQ-016 busy  out  1  high while any pipeline stage holds a valid result.

Function
REQ-017 Arbitration SHALL be round-robin: in RUN with drain=0, grant goes to the first requester with req_valid=1, searching from rr_ptr upward modulo NUM_REQ.
REQ-018 req_ready SHALL be combinational: high only for the granted requester; all zero in DRAIN, in DONE, or in RUN while drain=1.
REQ-019 A transfer SHALL occur on req_valid&req_ready; rr_ptr SHALL become (granted index+1) mod NUM_REQ on a transfer and hold otherwise.
REQ-020 mac_a/b/c SHALL combinationally carry the granted requester's operands; all zero when there is no grant.
REQ-021 On a transfer cycle, mac_z and the one-hot grant SHALL be captured into pipeline stage 1; stages shift every cycle unconditionally.
REQ-022 rsp_valid/rsp_data SHALL come from stage PIPE_LAT: a transfer at cycle t produces its response at cycle t+PIPE_LAT; rsp_data SHALL be zero when rsp_valid is zero.
REQ-023 Throughput SHALL be one transfer per cycle; responses have no backpressure and SHALL leave in issue order.
REQ-024 Withdrawal of req_valid before a transfer SHALL be legal and SHALL not change rr_ptr.
REQ-025 FSM states SHALL be RUN, DRAIN, DONE: RUN->DRAIN when drain=1; DRAIN->DONE when busy=0; DONE->RUN when drain=0; otherwise hold.
REQ-026 DRAIN SHALL ignore deassertion of drain and always continue to DONE.
REQ-027 drain_done SHALL be 1 exactly in DONE; drain asserted with an empty pipeline SHALL give drain_done two cycles after drain is first sampled.
REQ-028 busy SHALL be the OR of all stage valid bits.

Reset
REQ-029 Reset SHALL set state=RUN, rr_ptr=0, clear all stage valid, tag and data bits, and drive rsp_valid=0, rsp_data=0, drain_done=0, busy=0.
REQ-030 Reset mid-operation SHALL discard in-flight results; no rsp_valid SHALL assert for transfers made before reset.
REQ-031 While reset=1, req_ready SHALL be all zero.

Structure
REQ-032 Package mac_arb_pkg SHALL hold the state enum (RUN, DRAIN, DONE), FP_W=32, and RND_RNE=3'b000.
REQ-033 The delay line SHALL be the sub-module mac_rsp_pipe, parameterised by PIPE_LAT, NUM_REQ and FP_W.
REQ-034 The FP MAC SHALL stay outside this block.

Verification
REQ-035 Single issue: req0 sends a=0x3F800000, b=0x40000000, c=0x3F000000 at cycle t -> rsp_valid=2'b01 and rsp_data=0x40200000 at cycle t+2.
REQ-036 Contention: both requesters hold valid for 4 cycles from reset -> grants follow 0,1,0,1, with one response per cycle in that order.
REQ-037 Fairness: req1 holds valid, and req0 asserts valid only in the cycle after each req0 grant -> there are no two consecutive req0 grants while req1 is waiting.
REQ-038 Drain: issue 2 transfers, assert drain -> req_ready=0 immediately, both responses are delivered, drain_done=1 after busy falls; deassert drain -> RUN, and grants resume the next cycle.
REQ-039 Reset mid-flight: transfer at cycle t, reset at t+1 -> rsp_valid stays 0 through t+4, and rr_ptr=0.
REQ-040 Idle drain: drain=1 with an empty pipeline -> drain_done=1 exactly two cycles later.
